// File: rtl/seq_shift_unit.sv
// Iterative multi-mode shifter: one bit position per clock, start/busy/done handshake.
// Modes: LSL, LSR, ASR (sign-fill), ROR; the result is held in d_out until the next accepted start.
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [1:0]       mode_q,  mode_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] mode,
                                                   input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] res;
        case (mode)
            OP_LSL:  res = {val[WIDTH-2:0], 1'b0};
            OP_LSR:  res = {1'b0, val[WIDTH-1:1]};
            OP_ASR:  res = {val[WIDTH-1], val[WIDTH-1:1]};
            OP_ROR:  res = {val[0], val[WIDTH-1:1]};
            default: res = val;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        count_d = count_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    data_d  = d_in;
                    mode_d  = op;
                    count_d = shamt;
                    state_d = (shamt != '0) ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Inputs are deliberately not looked at here: start while busy is a no-op.
                data_d  = shift_one(mode_q, data_q);
                count_d = count_q - 1'b1;
                if (count_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            mode_q  <= OP_LSL;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d_out = data_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (WIDTH=8, SHW=3) with hand-computed expectations.
module tb_seq_shift_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [2:0] shamt = 3'd0;
    logic [7:0] d_in = 8'h00;
    logic [7:0] d_out;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    seq_shift_unit #(.WIDTH(8), .SHW(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .shamt   (shamt),
        .d_in    (d_in),
        .d_out   (d_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns just after the accepting edge with start low again.
    task automatic launch(input logic [1:0] o, input logic [2:0] s, input logic [7:0] d);
        op = o; shamt = s; d_in = d; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        vectors++;
        if (d_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_assert: d_out=%h busy=%b done=%b want 00 0 0", d_out, busy, done);
        end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (d_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: d_out=%h busy=%b done=%b want 00 0 0", i, d_out, busy, done);
            end
        end
    endtask

    task automatic test_asr3();
        logic [7:0] exp_seq [1:3];
        exp_seq[1] = 8'b1101_1101;
        exp_seq[2] = 8'b1110_1110;
        exp_seq[3] = 8'b1111_0111;
        launch(2'b10, 3'd3, 8'b1011_1011);
        vectors++;
        if (d_out !== 8'hBB || busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL asr3_load: d_out=%h busy=%b done=%b want bb 1 0", d_out, busy, done);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            vectors++;
            if (d_out !== exp_seq[k] || busy !== (k < 3) || done !== (k == 3)) begin
                miscompares++;
                $display("FAIL asr3_step%0d: d_out=%b busy=%b done=%b want %b %b %b",
                         k, d_out, busy, done, exp_seq[k], (k < 3), (k == 3));
            end
        end
        step();
        vectors++;
        if (d_out !== 8'hF7 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL asr3_hold: d_out=%h busy=%b done=%b want f7 0 0", d_out, busy, done);
        end
    endtask

    task automatic test_mode_sweep();
        logic [1:0] ops  [6];
        logic [2:0] amts [6];
        logic [7:0] ins  [6];
        logic [7:0] outs [6];
        int n;
        ops = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00};
        amts = '{3'd2, 3'd7, 3'd2, 3'd3, 3'd7, 3'd1};
        ins  = '{8'h59, 8'h59, 8'h59, 8'hBB, 8'h59, 8'h81};
        outs = '{8'h16, 8'h80, 8'h16, 8'h77, 8'hB2, 8'h02};
        for (int v = 0; v < 6; v++) begin
            launch(ops[v], amts[v], ins[v]);
            n = 0;
            while (done !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            vectors++;
            if (done !== 1'b1 || n != int'(amts[v]) || d_out !== outs[v]) begin
                miscompares++;
                $display("FAIL sweep%0d: done=%b cycles=%0d d_out=%h want 1 %0d %h",
                         v, done, n, d_out, amts[v], outs[v]);
            end
        end
        step();
    endtask

    task automatic test_shamt_zero();
        launch(2'b10, 3'd0, 8'hA5);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || d_out !== 8'hA5) begin
            miscompares++;
            $display("FAIL shamt0_done: done=%b busy=%b d_out=%h want 1 0 a5", done, busy, d_out);
        end
        step();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || d_out !== 8'hA5) begin
            miscompares++;
            $display("FAIL shamt0_after: done=%b busy=%b d_out=%h want 0 0 a5", done, busy, d_out);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        launch(2'b01, 3'd4, 8'hF0);
        step();
        n = 1;
        op = 2'b00; shamt = 3'd1; d_in = 8'hFF; start = 1'b1;
        step();
        n = 2;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || d_out !== 8'h3C) begin
            miscompares++;
            $display("FAIL busy_ignore_mid: busy=%b d_out=%h want 1 3c", busy, d_out);
        end
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (done !== 1'b1 || n != 4 || d_out !== 8'h0F) begin
            miscompares++;
            $display("FAIL busy_ignore_result: done=%b cycles=%0d d_out=%h want 1 4 0f", done, n, d_out);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        launch(2'b00, 3'd2, 8'h03);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (done !== 1'b1 || d_out !== 8'h0C) begin
            miscompares++;
            $display("FAIL b2b_first: done=%b d_out=%h want 1 0c", done, d_out);
        end
        launch(2'b11, 3'd1, 8'h01);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1 || d_out !== 8'h01) begin
            miscompares++;
            $display("FAIL b2b_accept: done=%b busy=%b d_out=%h want 0 1 01", done, busy, d_out);
        end
        step();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || d_out !== 8'h80) begin
            miscompares++;
            $display("FAIL b2b_second: done=%b busy=%b d_out=%h want 1 0 80", done, busy, d_out);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        logic saw_done;
        launch(2'b10, 3'd7, 8'h80);
        step();
        step();
        vectors++;
        if (busy !== 1'b1 || d_out !== 8'hE0) begin
            miscompares++;
            $display("FAIL rstmid_pre: busy=%b d_out=%h want 1 e0", busy, d_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (d_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_async: d_out=%h busy=%b done=%b want 00 0 0", d_out, busy, done);
        end
        step();
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0 || d_out !== 8'h00) begin
            miscompares++;
            $display("FAIL rstmid_quiet: activity=%b d_out=%h want 0 00", saw_done, d_out);
        end
        launch(2'b01, 3'd1, 8'h80);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (done !== 1'b1 || n != 1 || d_out !== 8'h40) begin
            miscompares++;
            $display("FAIL rstmid_resume: done=%b cycles=%0d d_out=%h want 1 1 40", done, n, d_out);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_asr3();
        test_mode_sweep();
        test_shamt_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
